// File: rtl/skip_arith_pkg.sv
// Shared types and helpers for the block-serial carry-skip subtractor.
package skip_arith_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompute = 2'd1,
        StDone    = 2'd2
    } state_e;

    function automatic int unsigned num_blocks(input int unsigned data_width,
                                               input int unsigned block_width);
        return data_width / block_width;
    endfunction

endpackage

// File: rtl/serial_skip_subtractor_if.sv
// Operand/result bundle for serial_skip_subtractor; slave is the subtractor's view.
interface serial_skip_subtractor_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] operand_A_i;
    logic [DATA_WIDTH-1:0] operand_B_i;
    logic                  borrow_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] result_o;
    logic                  borrow_o;
    logic                  overflow_o;
    logic                  valid_o;

    modport slave (
        input  operand_A_i,
        input  operand_B_i,
        input  borrow_i,
        input  valid_i,
        output ready_o,
        output result_o,
        output borrow_o,
        output overflow_o,
        output valid_o
    );

    modport master (
        output operand_A_i,
        output operand_B_i,
        output borrow_i,
        output valid_i,
        input  ready_o,
        input  result_o,
        input  borrow_o,
        input  overflow_o,
        input  valid_o
    );
endinterface

// File: rtl/borrow_skip_block.sv
// One BLOCK_WIDTH slice of A + ~B: ripple sum, with a skip mux bypassing the
// ripple carry when every bit propagates.
module borrow_skip_block #(
    parameter int unsigned BLOCK_WIDTH = 4
) (
    input  logic [BLOCK_WIDTH-1:0] a,
    input  logic [BLOCK_WIDTH-1:0] b_inv,
    input  logic                   carry_in,
    output logic [BLOCK_WIDTH-1:0] sum,
    output logic                   carry_out
);
    logic [BLOCK_WIDTH-1:0] prop;
    logic                   ripple_c;

    assign prop = a ^ b_inv;

    always_comb begin
        sum      = '0;
        ripple_c = carry_in;
        for (int i = 0; i < int'(BLOCK_WIDTH); i++) begin
            sum[i]   = prop[i] ^ ripple_c;
            ripple_c = (a[i] & b_inv[i]) | (prop[i] & ripple_c);
        end
    end

    assign carry_out = (&prop) ? carry_in : ripple_c;
endmodule

// File: rtl/serial_skip_subtractor.sv
// Block-serial subtractor: computes A - B - borrow_i one BLOCK_WIDTH slice per
// cycle through a single time-multiplexed carry-skip slice.
module serial_skip_subtractor
    import skip_arith_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BLOCK_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    serial_skip_subtractor_if.slave  bus
);
    localparam int unsigned NumBlocks = num_blocks(DATA_WIDTH, BLOCK_WIDTH);
    localparam int unsigned CntW      = (NumBlocks > 1) ? $clog2(NumBlocks) : 1;
    localparam logic [CntW-1:0] LastBlk = CntW'(NumBlocks - 1);
    localparam int unsigned Msb       = DATA_WIDTH - 1;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_inv_q, b_inv_d;
    logic                    carry_q, carry_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    borrow_q, borrow_d;
    logic                    overflow_q, overflow_d;
    logic                    valid_q, valid_d;

    int unsigned             slice_lo;
    logic [BLOCK_WIDTH-1:0]  slice_a;
    logic [BLOCK_WIDTH-1:0]  slice_b_inv;
    logic [BLOCK_WIDTH-1:0]  slice_sum;
    logic                    slice_carry;

    assign slice_lo    = BLOCK_WIDTH * cnt_q;
    assign slice_a     = a_q[slice_lo +: BLOCK_WIDTH];
    assign slice_b_inv = b_inv_q[slice_lo +: BLOCK_WIDTH];

    borrow_skip_block #(
        .BLOCK_WIDTH(BLOCK_WIDTH)
    ) u_slice (
        .a         (slice_a),
        .b_inv     (slice_b_inv),
        .carry_in  (carry_q),
        .sum       (slice_sum),
        .carry_out (slice_carry)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_inv_d    = b_inv_q;
        carry_d    = carry_q;
        result_d   = result_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.valid_i) begin
                    a_d     = bus.operand_A_i;
                    b_inv_d = ~bus.operand_B_i;
                    carry_d = ~bus.borrow_i;
                    cnt_d   = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                result_d[slice_lo +: BLOCK_WIDTH] = slice_sum;
                carry_d = slice_carry;
                if (cnt_q == LastBlk) begin
                    state_d    = StDone;
                    borrow_d   = ~slice_carry;
                    // b_inv_q holds ~B, so equal MSBs mean A and B differ in sign.
                    overflow_d = (a_q[Msb] == b_inv_q[Msb]) & (result_d[Msb] != a_q[Msb]);
                    valid_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            b_inv_q    <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_inv_q    <= b_inv_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.ready_o    = (state_q == StIdle);
    assign bus.result_o   = result_q;
    assign bus.borrow_o   = borrow_q;
    assign bus.overflow_o = overflow_q;
    assign bus.valid_o    = valid_q;
endmodule

// File: tb/tb_serial_skip_subtractor.sv
// Randomised bench for serial_skip_subtractor against an arithmetic reference model.
module tb_serial_skip_subtractor;
    localparam int unsigned Latency = 8;
    localparam int unsigned Period  = Latency + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_skip_subtractor_if #(.DATA_WIDTH(32)) bus ();

    serial_skip_subtractor #(
        .DATA_WIDTH (32),
        .BLOCK_WIDTH(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain wide unsigned and signed arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] r, output logic bo, output logic ov);
        logic [32:0] d;
        longint      t;
        d  = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        r  = d[31:0];
        bo = d[32];
        t  = longint'($signed(a)) - longint'($signed(b)) - longint'({63'd0, bin});
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [31:0] er;
        logic        eb, eo;
        int          k;
        model(a, b, bin, er, eb, eo);
        k = 0;
        while (bus.ready_o !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check_eq("ready_before_op", {63'd0, bus.ready_o}, 64'd1);
        bus.operand_A_i = a;
        bus.operand_B_i = b;
        bus.borrow_i    = bin;
        bus.valid_i     = 1'b1;
        tick();
        check_eq("ready_busy", {63'd0, bus.ready_o}, 64'd0);
        k = 0;
        while (bus.valid_o !== 1'b1 && k < 20) begin
            // Garbage on the inputs while busy must not disturb the operation.
            bus.operand_A_i = $urandom;
            bus.operand_B_i = $urandom;
            bus.borrow_i    = 1'($urandom_range(0, 1));
            bus.valid_i     = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        bus.valid_i = 1'b0;
        check_eq("latency", 64'(k), 64'(Latency));
        check_eq("result", {32'd0, bus.result_o}, {32'd0, er});
        check_eq("borrow", {63'd0, bus.borrow_o}, {63'd0, eb});
        check_eq("overflow", {63'd0, bus.overflow_o}, {63'd0, eo});
        tick();
        check_eq("valid_single", {63'd0, bus.valid_o}, 64'd0);
        check_eq("ready_after", {63'd0, bus.ready_o}, 64'd1);
        check_eq("result_hold", {32'd0, bus.result_o}, {32'd0, er});
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'h0000_0001;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] sa [40];
        logic [31:0] sb [40];
        logic        sbin [40];
        logic [31:0] er, a, b;
        logic        eb, eo;
        int          pulses;

        bus.operand_A_i = '0;
        bus.operand_B_i = '0;
        bus.borrow_i    = 1'b0;
        bus.valid_i     = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.valid_i = 1'b0;
        check_eq("rst_ready", {63'd0, bus.ready_o}, 64'd1);
        check_eq("rst_valid", {63'd0, bus.valid_o}, 64'd0);
        check_eq("rst_result", {32'd0, bus.result_o}, 64'd0);
        check_eq("rst_borrow", {63'd0, bus.borrow_o}, 64'd0);
        check_eq("rst_overflow", {63'd0, bus.overflow_o}, 64'd0);

        run_op(32'h0000_000A, 32'h0000_0003, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = pick_operand();
            b = ($urandom_range(0, 7) == 0) ? a : pick_operand();
            run_op(a, b, 1'($urandom_range(0, 1)));
        end

        // valid_i held high with fresh operands every cycle.
        for (int cyc = 0; cyc < 3 * int'(Period); cyc++) begin
            check_eq("stream_ready", {63'd0, bus.ready_o},
                     {63'd0, (cyc % int'(Period)) == 0});
            check_eq("stream_valid", {63'd0, bus.valid_o},
                     {63'd0, (cyc % int'(Period)) == int'(Period) - 1});
            if ((cyc % int'(Period)) == int'(Period) - 1) begin
                model(sa[cyc - int'(Latency) - 1], sb[cyc - int'(Latency) - 1],
                      sbin[cyc - int'(Latency) - 1], er, eb, eo);
                check_eq("stream_result", {32'd0, bus.result_o}, {32'd0, er});
                check_eq("stream_borrow", {63'd0, bus.borrow_o}, {63'd0, eb});
                check_eq("stream_overflow", {63'd0, bus.overflow_o}, {63'd0, eo});
            end
            sa[cyc]   = $urandom;
            sb[cyc]   = $urandom;
            sbin[cyc] = 1'($urandom_range(0, 1));
            bus.operand_A_i = sa[cyc];
            bus.operand_B_i = sb[cyc];
            bus.borrow_i    = sbin[cyc];
            bus.valid_i     = 1'b1;
            tick();
        end
        bus.valid_i = 1'b0;

        // Reset in the middle of COMPUTE aborts the operation.
        run_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b0);
        bus.operand_A_i = 32'h5555_5555;
        bus.operand_B_i = 32'h1111_1111;
        bus.borrow_i    = 1'b0;
        bus.valid_i     = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_ready", {63'd0, bus.ready_o}, 64'd1);
        check_eq("abort_valid", {63'd0, bus.valid_o}, 64'd0);
        check_eq("abort_result", {32'd0, bus.result_o}, 64'd0);
        check_eq("abort_borrow", {63'd0, bus.borrow_o}, 64'd0);
        check_eq("abort_overflow", {63'd0, bus.overflow_o}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.valid_o === 1'b1) pulses++;
        end
        check_eq("abort_no_pulse", 64'(pulses), 64'd0);
        run_op(32'h0000_0100, 32'h0000_0FFF, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_skip_subtractor.md
SERIAL_SKIP_SUBTRACTOR -- requirements
Module: serial_skip_subtractor

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter BLOCK_WIDTH, default 4, meaning the bits processed per cycle; DATA_WIDTH SHALL be an integer multiple of BLOCK_WIDTH.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port operand_A_i, input, DATA_WIDTH bits: the minuend.
REQ-006 The block SHALL have port operand_B_i, input, DATA_WIDTH bits: the subtrahend.
REQ-007 The block SHALL have port borrow_i, input, 1 bit: the borrow-in.
REQ-008 The block SHALL have port valid_i, input, 1 bit: operands valid.
REQ-009 The block SHALL have port ready_o, output, 1 bit: the block can accept a new operation.
REQ-010 The block SHALL have port result_o, output, DATA_WIDTH bits: A - B - borrow_i, modulo 2^DATA_WIDTH.
REQ-011 The block SHALL have port borrow_o, output, 1 bit: unsigned borrow-out.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: two's-complement signed overflow.
REQ-013 The block SHALL have port valid_o, output, 1 bit: a single-cycle pulse marking result_o, borrow_o and overflow_o as new.

Function
REQ-014 The block SHALL compute the difference as A + ~B + ~borrow_i, i.e. the internal carry-in = NOT borrow_i.
REQ-015 The block SHALL use an FSM with states IDLE, COMPUTE and DONE.
REQ-016 ready_o SHALL be 1 in IDLE only.
REQ-017 The block SHALL accept an operation when valid_i & ready_o at a rising edge.
REQ-018 On acceptance, the block SHALL register A, ~B and carry = ~borrow_i, clear the block counter to 0, and go to COMPUTE.
REQ-019 The block SHALL ignore valid_i and operand changes while ready_o = 0; the captured operands SHALL be unaffected.
REQ-020 In COMPUTE, each cycle SHALL process slice [BLOCK_WIDTH*k +: BLOCK_WIDTH], where k is the counter.
REQ-021 Each COMPUTE cycle SHALL write that result slice to the result register, update the carry register with the slice carry-out, and increment k.
REQ-022 The slice carry-out SHALL use carry-skip logic: if every bit of (A ^ ~B) in the slice is 1, carry-out = slice carry-in; otherwise carry-out = the ripple carry-out.
REQ-023 When k = DATA_WIDTH/BLOCK_WIDTH - 1, the block SHALL process the final slice and go to DONE; k SHALL never exceed DATA_WIDTH/BLOCK_WIDTH - 1 (no wrap).
REQ-024 On entering DONE, the block SHALL set borrow_o = NOT final carry, and overflow_o = (A[MSB] != B[MSB]) & (result[MSB] != A[MSB]).
REQ-025 In DONE, valid_o SHALL be 1 for exactly one cycle.
REQ-026 DONE SHALL go to IDLE unconditionally on the next edge.
REQ-027 Latency: with acceptance at edge N, valid_o SHALL be 1 in the cycle following edge N + DATA_WIDTH/BLOCK_WIDTH.
REQ-028 Throughput SHALL be one operation per DATA_WIDTH/BLOCK_WIDTH + 2 cycles.
REQ-029 result_o, borrow_o and overflow_o SHALL be registered and SHALL hold their last values until overwritten by the next operation.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-031 When rst_i = 1 at an edge, the block SHALL set state = IDLE, counter = 0, result_o = 0, borrow_o = 0, overflow_o = 0 and valid_o = 0.
REQ-032 ready_o SHALL be 1 from the first cycle after reset.
REQ-033 Reset asserted mid-COMPUTE or in DONE SHALL abort the operation, with no valid_o pulse for it.
REQ-034 rst_i SHALL take priority over valid_i at the same edge.

Structure
REQ-035 The state enum type, together with a function computing DATA_WIDTH/BLOCK_WIDTH, SHALL be placed in shared package skip_arith_pkg.
REQ-036 One sub-module, borrow_skip_block, SHALL implement one BLOCK_WIDTH slice.
REQ-037 borrow_skip_block SHALL be combinational: inputs a, b_inv and carry_in; outputs sum and carry_out; ripple path plus skip mux.
REQ-038 The top level SHALL instantiate exactly one borrow_skip_block, time-multiplexed by the counter.

Verification (DATA_WIDTH=32, BLOCK_WIDTH=4, latency 8)
REQ-039 A=0x0000000A, B=0x00000003, borrow_i=0 -> valid_o 8 cycles later; result 0x00000007, borrow_o=0, overflow_o=0.
REQ-040 A=0x00000000, B=0x00000001, borrow_i=0 -> result 0xFFFFFFFF, borrow_o=1, overflow_o=0.
REQ-041 A=0x80000000, B=0x00000001, borrow_i=0 -> result 0x7FFFFFFF, borrow_o=0, overflow_o=1.
REQ-042 A=B=0x12345678, borrow_i=1 (every slice takes the skip path) -> result 0xFFFFFFFF, borrow_o=1, overflow_o=0.
REQ-043 valid_i held high with changing operands during COMPUTE -> only the first operation completes; the next is accepted in the cycle after valid_o; no valid_o pulse is dropped or duplicated.
REQ-044 rst_i=1 at COMPUTE cycle 4 -> no valid_o; outputs 0; ready_o=1 in the next cycle; a following operation completes correctly.
